calc_seq_ctrl: RTL and testbench



---
 rtl/calc_seq_ctrl_pkg.sv | 14 +
 rtl/calc_seq_ctrl_cells.sv | 33 +++
 rtl/calc_seq_ctrl.sv | 115 +++++++++++
 tb/tb_calc_seq_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/calc_seq_ctrl_pkg.sv
// calc_pkg: shared state encoding and widths for the sequential (A+B)-(C+D) calculator
package calc_pkg;
   localparam int CALC_W = 4;
   localparam int SUM_W = CALC_W + 1;
   localparam int CNT_W = $clog2(SUM_W);
   localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(SUM_W - 1);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SUM_AB = 3'd1,
      SUM_CD = 3'd2,
      SUB    = 3'd3,
      DONE   = 3'd4
   } state_t;
endpackage

// File: rtl/calc_seq_ctrl_cells.sv
// calc_seq_ctrl_cells: the fixed-width carry-lookahead adder and one-bit subtractor cells
module CLA_4b (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;
   assign g = a & b;
   assign p = a ^ b;
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);
   assign s = p ^ c[3:0];
   assign cout = c[4];
endmodule

module subber (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic D,
   output logic Bout
);
   assign D = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: computes (A+B)-(C+D) with one shared adder and a bit-serial subtractor
module calc_seq_ctrl
   import calc_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic [W-1:0] C,
   input  logic [W-1:0] D,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   F,
   output logic         neg
);
   if (W != CALC_W) begin : g_bad_w
      $error("calc_seq_ctrl: W must be 4, the CLA_4b width");
   end

   state_t state_q, state_d;
   logic [CALC_W-1:0] a_q, b_q, c_q, d_q;
   logic [SUM_W-1:0] sum1, sum2, f_q;
   logic [CNT_W-1:0] bit_cnt;
   logic borrow, neg_q;
   logic [CALC_W-1:0] add_x, add_y, add_s;
   logic add_co, sub_d, sub_b;

   assign add_x = (state_q == SUM_AB) ? a_q : c_q;
   assign add_y = (state_q == SUM_AB) ? b_q : d_q;

   CLA_4b u_cla (
      .a    (add_x),
      .b    (add_y),
      .cin  (1'b0),
      .s    (add_s),
      .cout (add_co)
   );

   subber u_sub (
      .A    (sum1[bit_cnt]),
      .B    (sum2[bit_cnt]),
      .Bin  (borrow),
      .D    (sub_d),
      .Bout (sub_b)
   );

   assign F = f_q;
   assign neg = neg_q;

   // State register; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   end

   // Sequencing and handshake outputs
   always_comb begin
      state_d = state_q;
      in_ready = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = SUM_AB;
         end
         SUM_AB: state_d = SUM_CD;
         SUM_CD: state_d = SUB;
         SUB: if (bit_cnt == SUB_LAST) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, sum capture and bit-serial subtraction into F
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         d_q <= '0;
         sum1 <= '0;
         sum2 <= '0;
         f_q <= '0;
         bit_cnt <= '0;
         borrow <= 1'b0;
         neg_q <= 1'b0;
      end else begin
         if (state_q == IDLE && in_valid) begin
            a_q <= A;
            b_q <= B;
            c_q <= C;
            d_q <= D;
         end
         if (state_q == SUM_AB) sum1 <= {add_co, add_s};
         if (state_q == SUM_CD) begin
            sum2 <= {add_co, add_s};
            bit_cnt <= '0;
            borrow <= 1'b0;
         end
         if (state_q == SUB) begin
            f_q[bit_cnt] <= sub_d;
            borrow <= sub_b;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == SUB_LAST) neg_q <= sub_b;
         end
      end
   end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed checks of latency, arithmetic, backpressure, reset abort and back-to-back operation
module tb_calc_seq_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [3:0] A = '0, B = '0, C = '0, D = '0;
   logic in_ready, out_valid, neg;
   logic [4:0] F;
   int compared = 0;
   int mismatched = 0;
   int acc_edge = 0;

   always #5 clk = ~clk;

   calc_seq_ctrl #(.W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .F         (F),
      .neg       (neg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic launch(input string tag, input logic [3:0] a, b, c, d);
      @(negedge clk);
      check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      A = a; B = b; C = c; D = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic finish_op(input string tag, input logic [4:0] ef, input logic en);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check({tag, "_not_early"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_F"}, 32'(F), 32'(ef));
      check({tag, "_neg"}, 32'(neg), 32'(en));
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_back_idle"}, 32'(in_ready), 32'd1);
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_F", 32'(F), 32'd0);
      check("rst_neg", 32'(neg), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      launch("basic", 4'd9, 4'd6, 4'd3, 4'd2);
      finish_op("basic", 5'b01010, 1'b0);
      launch("negres", 4'd1, 4'd2, 4'd15, 4'd15);
      finish_op("negres", 5'b00101, 1'b1);
      launch("maxpos", 4'd15, 4'd15, 4'd0, 4'd0);
      finish_op("maxpos", 5'b11110, 1'b0);
      launch("allmax", 4'd15, 4'd15, 4'd15, 4'd15);
      finish_op("allmax", 5'b00000, 1'b0);

      out_ready = 1'b0;
      launch("bp", 4'd2, 4'd3, 4'd1, 4'd0);
      repeat (7) @(posedge clk);
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_F", 32'(F), 32'd4);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         A = 4'd15; B = 4'd15; C = 4'd15; D = 4'd15;
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_F", 32'(F), 32'd4);
         check("bp_hold_neg", 32'(neg), 32'd0);
         check("bp_hold_busy", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_idle", 32'(in_ready), 32'd1);
      check("bp_release_valid", 32'(out_valid), 32'd0);

      launch("rst_mid", 4'd7, 4'd7, 4'd7, 4'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_F", 32'(F), 32'd0);
      check("abort_neg", 32'(neg), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_valid", 32'(out_valid), 32'd0);
      end
      rst_n = 1'b1;
      launch("post_rst", 4'd4, 4'd4, 4'd1, 4'd1);
      finish_op("post_rst", 5'd6, 1'b0);

      @(negedge clk);
      A = 4'd5; B = 4'd5; C = 4'd2; D = 4'd1;
      in_valid = 1'b1;
      check("b2b_idle_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      A = 4'd0; B = 4'd1; C = 4'd7; D = 4'd8;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (acc_edge == 0 && in_ready && in_valid) acc_edge = k + 1;
         if (k == 6) check("b2b1_not_early", 32'(out_valid), 32'd0);
         if (k == 7) begin
            check("b2b1_valid", 32'(out_valid), 32'd1);
            check("b2b1_F", 32'(F), 32'd7);
            check("b2b1_neg", 32'(neg), 32'd0);
         end
         if (k == 9) in_valid = 1'b0;
         if (k == 15) check("b2b2_not_early", 32'(out_valid), 32'd0);
         if (k == 16) begin
            check("b2b2_valid", 32'(out_valid), 32'd1);
            check("b2b2_F", 32'(F), 32'd18);
            check("b2b2_neg", 32'(neg), 32'd1);
         end
         if (k == 17) check("b2b2_idle", 32'(in_ready), 32'd1);
      end
      check("b2b_accept_edge", 32'(acc_edge), 32'd9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
